// File: rtl/oob_host_ctrl.sv
// Host-side SATA OOB initialization controller: COMINIT/COMWAKE handshake,
// D10.2 -> ALIGN -> SYNC bring-up, with timeouts back to IDLE.
module oob_host_ctrl #(
  parameter int NOCOMWAKE_CYCLES = 38,
  parameter int COMINIT_TIMEOUT  = 131070,
  parameter int COMWAKE_TIMEOUT  = 131070,
  parameter int ALIGN_TIMEOUT    = 131070
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gtx_ready,
  input  logic        oob_start,
  input  logic        rxcominitdet_in,
  input  logic        rxcomwakedet_in,
  input  logic        rxelecidle_in,
  input  logic [31:0] rxdata_in,
  input  logic [3:0]  rxcharisk_in,
  output logic        txcominit,
  output logic        txcomwake,
  output logic        txelecidle,
  output logic [31:0] txdata_out,
  output logic [3:0]  txcharisk_out,
  output logic        link_up,
  output logic        oob_busy,
  output logic        oob_silence,
  output logic        oob_error
);

  localparam logic [31:0] ALIGN_D = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_D  = 32'hB5B5957C;
  localparam logic [31:0] D102_D  = 32'h4A4A4A4A;

  localparam int NCW_W = (NOCOMWAKE_CYCLES < 2) ? 1 : $clog2(NOCOMWAKE_CYCLES);
  localparam logic [NCW_W-1:0] NCW_LAST = NCW_W'(NOCOMWAKE_CYCLES - 1);

  localparam logic [17:0] T_CI = 18'(COMINIT_TIMEOUT);
  localparam logic [17:0] T_CW = 18'(COMWAKE_TIMEOUT);
  localparam logic [17:0] T_AL = 18'(ALIGN_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_COMINIT,
    S_WAIT_COMINIT,
    S_SEND_COMWAKE,
    S_WAIT_COMWAKE,
    S_WAIT_NOCOMWAKE,
    S_WAIT_ALIGN,
    S_SEND_ALIGN,
    S_READY,
    S_ERROR
  } state_t;

  state_t state, state_nx;

  logic             rx_cominit, rx_comwake, rx_eidle;
  logic [31:0]      rx_data;
  logic [3:0]       rx_k;
  logic [17:0]      timer, timer_nx;
  logic [NCW_W-1:0] ncw_cnt, ncw_nx;
  logic [1:0]       sync_cnt, sync_nx;
  logic             silence_nx;
  logic             rx_is_align, rx_is_prim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cominit <= 1'b0;
      rx_comwake <= 1'b0;
      rx_eidle   <= 1'b0;
      rx_data    <= '0;
      rx_k       <= '0;
    end else begin
      rx_cominit <= rxcominitdet_in;
      rx_comwake <= rxcomwakedet_in;
      rx_eidle   <= rxelecidle_in;
      rx_data    <= rxdata_in;
      rx_k       <= rxcharisk_in;
    end
  end

  assign rx_is_align = (rx_k == 4'h1) && (rx_data == ALIGN_D);
  assign rx_is_prim  = (rx_k == 4'h1) && !rx_is_align;

  always_comb begin
    state_nx   = state;
    silence_nx = 1'b0;
    ncw_nx     = ncw_cnt;
    sync_nx    = sync_cnt;
    unique case (state)
      S_IDLE: begin
        if (rx_cominit)     state_nx = S_SEND_COMWAKE;
        else if (oob_start) state_nx = S_SEND_COMINIT;
      end
      S_SEND_COMINIT: state_nx = S_WAIT_COMINIT;
      S_WAIT_COMINIT: begin
        if (rx_cominit) state_nx = S_SEND_COMWAKE;
        else if (timer == T_CI) begin
          state_nx   = S_IDLE;
          silence_nx = 1'b1;
        end
      end
      S_SEND_COMWAKE: state_nx = S_WAIT_COMWAKE;
      S_WAIT_COMWAKE: begin
        if (rx_comwake)        state_nx = S_WAIT_NOCOMWAKE;
        else if (timer == T_CW) state_nx = S_ERROR;
      end
      S_WAIT_NOCOMWAKE: begin
        if (rx_comwake)              ncw_nx   = '0;
        else if (ncw_cnt == NCW_LAST) state_nx = S_WAIT_ALIGN;
        else                          ncw_nx   = ncw_cnt + 1'b1;
      end
      S_WAIT_ALIGN: begin
        if (rx_is_align)        state_nx = S_SEND_ALIGN;
        else if (timer == T_AL) state_nx = S_ERROR;
      end
      S_SEND_ALIGN: begin
        // Third back-to-back non-ALIGN primitive completes the handshake.
        if (rx_is_align) sync_nx = '0;
        else if (rx_is_prim) begin
          if (sync_cnt == 2'd2) state_nx = S_READY;
          else                  sync_nx  = sync_cnt + 2'd1;
        end
      end
      S_READY: begin
        if (rx_eidle || rx_cominit) state_nx = S_IDLE;
      end
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (state_nx != state) begin
      ncw_nx  = '0;
      sync_nx = '0;
    end

    if (!gtx_ready) begin
      state_nx   = S_IDLE;
      silence_nx = 1'b0;
      ncw_nx     = '0;
      sync_nx    = '0;
    end

    timer_nx = timer;
    if (state_nx != state) timer_nx = '0;
    else if (state == S_WAIT_COMINIT || state == S_WAIT_COMWAKE || state == S_WAIT_ALIGN)
      timer_nx = timer + 18'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      ncw_cnt  <= '0;
      sync_cnt <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      ncw_cnt  <= ncw_nx;
      sync_cnt <= sync_nx;
    end
  end

  // Outputs are registered decodes of the next state, aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txcominit     <= 1'b0;
      txcomwake     <= 1'b0;
      txelecidle    <= 1'b1;
      txdata_out    <= '0;
      txcharisk_out <= '0;
      link_up       <= 1'b0;
      oob_busy      <= 1'b0;
      oob_silence   <= 1'b0;
      oob_error     <= 1'b0;
    end else begin
      txcominit   <= (state_nx == S_SEND_COMINIT);
      txcomwake   <= (state_nx == S_SEND_COMWAKE);
      txelecidle  <= !(state_nx == S_WAIT_ALIGN || state_nx == S_SEND_ALIGN ||
                       state_nx == S_READY);
      link_up     <= (state_nx == S_READY);
      oob_busy    <= (state_nx != S_IDLE);
      oob_silence <= silence_nx;
      oob_error   <= (state_nx == S_ERROR);
      unique case (state_nx)
        S_WAIT_ALIGN: begin
          txdata_out    <= D102_D;
          txcharisk_out <= 4'h0;
        end
        S_SEND_ALIGN: begin
          txdata_out    <= ALIGN_D;
          txcharisk_out <= 4'h1;
        end
        S_READY: begin
          txdata_out    <= SYNC_D;
          txcharisk_out <= 4'h1;
        end
        default: begin
          txdata_out    <= '0;
          txcharisk_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oob_host_ctrl.sv
// Self-checking bench for oob_host_ctrl: scoreboarded expectations plus
// hand-written sequences for timeouts, priority and asynchronous reset.
module tb_oob_host_ctrl;

  localparam logic [31:0] ALIGN_D = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_D  = 32'hB5B5957C;
  localparam logic [31:0] D102_D  = 32'h4A4A4A4A;
  localparam int TMO = 200;

  // Flag order: {txcominit, txcomwake, txelecidle, link_up, oob_busy, oob_silence, oob_error}
  localparam logic [6:0] F_IDLE = 7'b0010000;
  localparam logic [6:0] F_SCI  = 7'b1010100;
  localparam logic [6:0] F_WAIT = 7'b0010100;
  localparam logic [6:0] F_SCW  = 7'b0110100;
  localparam logic [6:0] F_TX   = 7'b0000100;
  localparam logic [6:0] F_RDY  = 7'b0001100;
  localparam logic [6:0] F_SIL  = 7'b0010010;
  localparam logic [6:0] F_ERR  = 7'b0010101;

  logic        clk = 1'b0;
  logic        rst_n, gtx_ready, oob_start;
  logic        rx_cominit, rx_comwake, rx_eidle;
  logic [31:0] rx_data;
  logic [3:0]  rx_k;
  logic        txcominit, txcomwake, txelecidle, link_up, oob_busy, oob_silence, oob_error;
  logic [31:0] txdata_out;
  logic [3:0]  txcharisk_out;

  oob_host_ctrl #(
    .NOCOMWAKE_CYCLES(38),
    .COMINIT_TIMEOUT (TMO),
    .COMWAKE_TIMEOUT (TMO),
    .ALIGN_TIMEOUT   (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gtx_ready      (gtx_ready),
    .oob_start      (oob_start),
    .rxcominitdet_in(rx_cominit),
    .rxcomwakedet_in(rx_comwake),
    .rxelecidle_in  (rx_eidle),
    .rxdata_in      (rx_data),
    .rxcharisk_in   (rx_k),
    .txcominit      (txcominit),
    .txcomwake      (txcomwake),
    .txelecidle     (txelecidle),
    .txdata_out     (txdata_out),
    .txcharisk_out  (txcharisk_out),
    .link_up        (link_up),
    .oob_busy       (oob_busy),
    .oob_silence    (oob_silence),
    .oob_error      (oob_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       nm;
    logic [42:0] v;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        link;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp = 0, n_bad = 0;
  int   slot = 0;
  int   n_ci = 0, n_cw = 0;

  function automatic logic [42:0] mk(logic [6:0] f, logic [31:0] d, logic [3:0] k);
    return {f, d, k};
  endfunction

  function automatic logic [42:0] outv();
    return {txcominit, txcomwake, txelecidle, link_up, oob_busy, oob_silence, oob_error,
            txdata_out, txcharisk_out};
  endfunction

  function automatic void chk(string nm, logic [42:0] got, logic [42:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got flags=%b data=%h k=%h, expected flags=%b data=%h k=%h",
               nm, got[42:36], got[35:4], got[3:0], exp[42:36], exp[35:4], exp[3:0]);
    end
  endfunction

  function automatic void chk_int(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endfunction

  function automatic void push(int due, string nm, logic [42:0] v);
    exp_t e;
    e.due = due;
    e.nm  = nm;
    e.v   = v;
    sb.push_back(e);
  endfunction

  task automatic step();
    @(negedge clk);
    slot++;
    if (txcominit) n_ci++;
    if (txcomwake) n_cw++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= slot) begin
        chk(sb[i].nm, outv(), sb[i].v);
        sb.delete(i);
      end
    end
  endtask

  // From WAIT_COMWAKE: short COMWAKE burst, then wait for the D10.2 phase.
  task automatic reach_align();
    int t;
    rx_comwake = 1'b1;
    step();
    step();
    rx_comwake = 1'b0;
    t = 0;
    while (txelecidle && t < 100) begin
      step();
      t++;
    end
    chk_int("reach_wait_align", int'(txelecidle), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, l, eidle_bad;

    tbl[0] = '{ALIGN_D, 4'h1, 1'b0};
    tbl[1] = '{SYNC_D,  4'h1, 1'b0};
    tbl[2] = '{SYNC_D,  4'h1, 1'b0};
    tbl[3] = '{ALIGN_D, 4'h1, 1'b0};
    tbl[4] = '{SYNC_D,  4'h1, 1'b0};
    tbl[5] = '{SYNC_D,  4'h1, 1'b0};
    tbl[6] = '{SYNC_D,  4'h1, 1'b1};
    tbl[7] = '{SYNC_D,  4'h1, 1'b1};

    rst_n = 1'b0; gtx_ready = 1'b1; oob_start = 1'b0;
    rx_cominit = 1'b0; rx_comwake = 1'b0; rx_eidle = 1'b0;
    rx_data = '0; rx_k = '0;
    repeat (3) step();
    chk("reset_state", outv(), mk(F_IDLE, '0, '0));
    rst_n = 1'b1;
    step();
    n_ci = 0; n_cw = 0;

    // Normal bring-up
    oob_start = 1'b1;
    push(slot + 1, "send_cominit", mk(F_SCI, '0, '0));
    push(slot + 2, "wait_cominit", mk(F_WAIT, '0, '0));
    step();
    oob_start = 1'b0;
    repeat (10) step();
    rx_cominit = 1'b1;
    push(slot + 2, "send_comwake", mk(F_SCW, '0, '0));
    push(slot + 3, "wait_comwake", mk(F_WAIT, '0, '0));
    step();
    rx_cominit = 1'b0;
    repeat (5) step();
    rx_comwake = 1'b1;
    repeat (4) step();
    l = slot;
    push(l + 39, "nocomwake_hold", mk(F_WAIT, '0, '0));
    push(l + 40, "d102_start", mk(F_TX, D102_D, 4'h0));
    step();
    rx_comwake = 1'b0;
    repeat (40) step();
    rx_data = ALIGN_D; rx_k = 4'h1;
    push(slot + 1, "d102_before_align", mk(F_TX, D102_D, 4'h0));
    push(slot + 2, "align_out", mk(F_TX, ALIGN_D, 4'h1));
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      rx_data = tbl[i].d;
      rx_k    = tbl[i].k;
      push(slot + 2, $sformatf("sync_vec%0d", i),
           tbl[i].link ? mk(F_RDY, SYNC_D, 4'h1) : mk(F_TX, ALIGN_D, 4'h1));
      step();
    end
    step();
    step();
    chk_int("bringup_cominit_pulses", n_ci, 1);
    chk_int("bringup_comwake_pulses", n_cw, 1);

    // Link drop from READY
    rx_eidle = 1'b1;
    push(slot + 1, "ready_hold", mk(F_RDY, SYNC_D, 4'h1));
    push(slot + 2, "link_drop", mk(F_IDLE, '0, '0));
    step();
    rx_eidle = 1'b0; rx_data = '0; rx_k = '0;
    step();
    step();

    // No device: COMINIT timeout
    oob_start = 1'b1;
    step();
    chk("nodev_send_cominit", outv(), mk(F_SCI, '0, '0));
    oob_start = 1'b0;
    step();
    t = 0; eidle_bad = 0;
    while (!oob_silence && t < 400) begin
      step();
      t++;
      if (!txelecidle) eidle_bad++;
    end
    // Timer clears on entry and compares against the limit; the registered pulse follows one edge later.
    chk_int("silence_latency", t, TMO + 1);
    chk("silence_pulse", outv(), mk(F_SIL, '0, '0));
    step();
    chk("silence_idle", outv(), mk(F_IDLE, '0, '0));
    chk_int("nodev_txelecidle", eidle_bad, 0);

    // gtx_ready low forces IDLE at the next edge
    oob_start = 1'b1;
    step();
    oob_start = 1'b0;
    step();
    step();
    gtx_ready = 1'b0;
    push(slot + 1, "gtx_ready_low", mk(F_IDLE, '0, '0));
    step();
    gtx_ready = 1'b1;
    step();

    // COMINIT beats oob_start in IDLE
    n_ci = 0; n_cw = 0;
    rx_cominit = 1'b1;
    step();
    rx_cominit = 1'b0;
    oob_start  = 1'b1;
    push(slot + 1, "prio_comwake", mk(F_SCW, '0, '0));
    push(slot + 2, "prio_wait", mk(F_WAIT, '0, '0));
    step();
    oob_start = 1'b0;
    step();
    chk_int("prio_no_cominit", n_ci, 0);
    chk_int("prio_one_comwake", n_cw, 1);

    // ALIGN timeout
    rx_data = D102_D; rx_k = 4'h0;
    reach_align();
    t = 0;
    while (!oob_error && t < 400) begin
      step();
      t++;
    end
    chk_int("align_timeout_latency", t, TMO + 1);
    chk("align_error_pulse", outv(), mk(F_ERR, '0, '0));
    step();
    chk("align_error_idle", outv(), mk(F_IDLE, '0, '0));

    // Asynchronous reset in SEND_ALIGN
    rx_data = '0; rx_k = '0;
    oob_start = 1'b1;
    step();
    oob_start = 1'b0;
    repeat (3) step();
    rx_cominit = 1'b1;
    step();
    rx_cominit = 1'b0;
    repeat (3) step();
    rx_data = D102_D;
    reach_align();
    rx_data = ALIGN_D; rx_k = 4'h1;
    step();
    step();
    chk("pre_reset_send_align", outv(), mk(F_TX, ALIGN_D, 4'h1));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_immediate", outv(), mk(F_IDLE, '0, '0));
    step();
    chk("async_reset_held", outv(), mk(F_IDLE, '0, '0));
    rst_n = 1'b1;
    step();
    step();
    chk("after_reset_idle", outv(), mk(F_IDLE, '0, '0));

    chk_int("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
